bsram_ctl: RTL and testbench

- Parametrised successor of the single-read/single-write block RAM: one sync read port, one sync write port with byte enables.
- Adds selectable read-during-write behaviour, optional second output register with read-valid, and a built-in clear engine that sweeps the array to a fill value after reset or on request.
- Shared building block for program/data/framebuffer memories.
- Storage is inferred block RAM and is never touched by the async reset.

---
 rtl/bsram_ctl.sv | 153 +++++++++++++++
 tb/tb_bsram_ctl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsram_ctl.sv
// Byte-enabled block RAM with one sync read port and one sync write port,
// selectable read-during-write, optional output stage and a clear engine.
module bsram_ctl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 13,
  parameter int SIZE           = 8192,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    clear_req,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;
  localparam logic ST_RST   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);

  logic                  state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [0:SIZE-1];

  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rd_oor;
  logic [IW-1:0]         rd_idx;
  logic                  mem_we;
  logic [IW-1:0]         mem_idx;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_din;

  assign busy   = (state == ST_CLEAR);
  assign wr_ok  = we & ~busy & (32'(wr_addr) < SIZE);
  assign rd_ok  = rd_en & ~busy;
  assign rd_oor = (32'(rd_addr) >= SIZE);
  assign rd_idx = rd_oor ? '0 : rd_addr[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The clear engine owns the write port for the whole sweep.
  assign mem_we  = busy | wr_ok;
  assign mem_idx = busy ? cnt[IW-1:0] : wr_addr[IW-1:0];
  assign mem_be  = busy ? '1 : wr_be;
  assign mem_din = busy ? CLEAR_VALUE : wr_data;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b+:8] <= mem_din[8*b+:8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] ram_q;
  logic                  v0;
  logic                  oor0;
  logic                  fwd0;
  logic [NB-1:0]         fbe0;
  logic [DATA_WIDTH-1:0] fdat0;
  logic [DATA_WIDTH-1:0] word0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q <= '0;
      v0    <= 1'b0;
      oor0  <= 1'b0;
      fwd0  <= 1'b0;
      fbe0  <= '0;
      fdat0 <= '0;
    end else begin
      v0 <= rd_ok;
      if (rd_ok) begin
        ram_q <= mem[rd_idx];
        oor0  <= rd_oor;
        fwd0  <= (RDW_MODE != 0) && wr_ok && (rd_addr == wr_addr);
        fbe0  <= wr_be;
        fdat0 <= wr_data;
      end
    end
  end

  // Same-address write is merged here rather than through the RAM primitive.
  always_comb begin
    word0 = ram_q;
    if (fwd0) begin
      for (int b = 0; b < NB; b++) begin
        if (fbe0[b]) word0[8*b+:8] = fdat0[8*b+:8];
      end
    end
    if (oor0) word0 = '0;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r1;
      logic                  v1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r1 <= '0;
          v1 <= 1'b0;
        end else begin
          v1 <= v0;
          if (v0) r1 <= word0;
        end
      end
      assign rd_data  = r1;
      assign rd_valid = v1;
    end else begin : g_lat1
      assign rd_data  = word0;
      assign rd_valid = v0;
    end
  endgenerate

endmodule

// File: tb/tb_bsram_ctl.sv
// Directed bench for bsram_ctl: instance a is latency 1 / old-data,
// instance b is latency 2 / new-data; both share one stimulus.
module tb_bsram_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic        we;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        clear_req;

  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic        busy_a, busy_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bsram_ctl #(
    .DATA_WIDTH(16), .ADDR_WIDTH(5), .SIZE(16), .READ_LATENCY(1),
    .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clear_req(clear_req), .busy(busy_a)
  );

  bsram_ctl #(
    .DATA_WIDTH(16), .ADDR_WIDTH(5), .SIZE(16), .READ_LATENCY(2),
    .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clear_req(clear_req), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rd_en = 0; rd_addr = 0; we = 0; wr_addr = 0;
    wr_data = 0; wr_be = 0; clear_req = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d,
                    input logic [1:0] be);
    we = 1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    we = 0; wr_be = 0;
  endtask

  task automatic test_reset();
    int na, nb;
    idle_in();
    rst_n = 0;
    step(); step();
    total++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      $display("FAIL reset_busy a=%b b=%b want 1", busy_a, busy_b);
    end else passed++;
    total++;
    if (rd_data_a !== 16'h0 || rd_valid_a !== 1'b0 ||
        rd_data_b !== 16'h0 || rd_valid_b !== 1'b0) begin
      $display("FAIL reset_rd a=%h/%b b=%h/%b want 0/0",
               rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
    end else passed++;
    rst_n = 1;
    na = 0; nb = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      step();
    end
    total++;
    if (na != 16 || nb != 16) begin
      $display("FAIL reset_sweep_len a=%0d b=%0d want 16", na, nb);
    end else passed++;
  endtask

  task automatic test_clear_contents();
    int bad_a, bad_b;
    bad_a = 0; bad_b = 0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; rd_addr = 5'(i);
      step();
      if (rd_valid_a !== 1'b1 || rd_data_a !== 16'hA5A5) bad_a++;
      if (i > 0 && (rd_valid_b !== 1'b1 || rd_data_b !== 16'hA5A5)) bad_b++;
      if (i == 0 && rd_valid_b !== 1'b0) bad_b++;
    end
    rd_en = 0;
    step();
    total++;
    if (bad_a != 0) begin
      $display("FAIL clear_read_a errors=%0d want 0", bad_a);
    end else passed++;
    total++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 16'hA5A5) begin
      $display("FAIL clear_hold_a got %h/%b want a5a5/0",
               rd_data_a, rd_valid_a);
    end else passed++;
    total++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 16'hA5A5) bad_b++;
    step();
    if (rd_valid_b !== 1'b0) bad_b++;
    if (bad_b != 0) begin
      $display("FAIL clear_read_b errors=%0d want 0", bad_b);
    end else passed++;
  endtask

  task automatic test_byte_enables();
    wr(5'd3, 16'h1234, 2'b11);
    wr(5'd3, 16'hFF00, 2'b10);
    rd_en = 1; rd_addr = 5'd3;
    step();
    rd_en = 0;
    total++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'hFF34) begin
      $display("FAIL be_merge_a got %h/%b want ff34/1",
               rd_data_a, rd_valid_a);
    end else passed++;
    step();
    total++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 16'hFF34) begin
      $display("FAIL be_merge_b got %h/%b want ff34/1",
               rd_data_b, rd_valid_b);
    end else passed++;
    wr(5'd3, 16'h0000, 2'b00);
    rd_en = 1; rd_addr = 5'd3;
    step();
    rd_en = 0;
    total++;
    if (rd_data_a !== 16'hFF34) begin
      $display("FAIL be_zero got %h want ff34", rd_data_a);
    end else passed++;
    step();
  endtask

  task automatic test_rdw();
    wr(5'd5, 16'h0001, 2'b11);
    we = 1; wr_addr = 5'd5; wr_data = 16'hBEEF; wr_be = 2'b01;
    rd_en = 1; rd_addr = 5'd5;
    step();
    idle_in();
    total++;
    if (rd_data_a !== 16'h0001 || rd_valid_a !== 1'b1) begin
      $display("FAIL rdw_old got %h/%b want 0001/1", rd_data_a, rd_valid_a);
    end else passed++;
    step();
    total++;
    if (rd_data_b !== 16'h00EF || rd_valid_b !== 1'b1) begin
      $display("FAIL rdw_new got %h/%b want 00ef/1", rd_data_b, rd_valid_b);
    end else passed++;
    rd_en = 1; rd_addr = 5'd5;
    step();
    rd_en = 0;
    total++;
    if (rd_data_a !== 16'h00EF) begin
      $display("FAIL rdw_after got %h want 00ef", rd_data_a);
    end else passed++;
    step();
  endtask

  task automatic test_out_of_range();
    wr(5'd20, 16'hDEAD, 2'b11);
    rd_en = 1; rd_addr = 5'd20;
    step();
    rd_addr = 5'd4;
    total++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0000) begin
      $display("FAIL oor_read got %h/%b want 0000/1", rd_data_a, rd_valid_a);
    end else passed++;
    step();
    rd_en = 0;
    total++;
    if (rd_data_a !== 16'hA5A5) begin
      $display("FAIL oor_write_alias got %h want a5a5", rd_data_a);
    end else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_b [0:4];
    logic        expv_b [0:4];
    int bad;
    exp_b  = '{16'hA5A5, 16'h1111, 16'h2222, 16'h3333, 16'h3333};
    expv_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    wr(5'd0, 16'h1111, 2'b11);
    wr(5'd1, 16'h2222, 2'b11);
    wr(5'd2, 16'h3333, 2'b11);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      rd_en = (i < 3); rd_addr = 5'(i);
      step();
      if (rd_valid_b !== expv_b[i]) bad++;
      if (i > 0 && rd_data_b !== exp_b[i]) bad++;
    end
    rd_en = 0;
    total++;
    if (bad != 0) begin
      $display("FAIL lat2_b2b errors=%0d want 0 last=%h/%b",
               bad, rd_data_b, rd_valid_b);
    end else passed++;
  endtask

  task automatic test_busy_gating();
    int n, va, vb;
    clear_req = 1;
    step();
    clear_req = 0;
    n = 0; va = 0; vb = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy_a) n++;
      if (i == 1 || i == 2 || i == 13 || i == 14) begin
        if (rd_valid_a) va++;
        if (rd_valid_b) vb++;
      end
      rd_en = (i == 0 || i == 12); rd_addr = 5'd7;
      we = (i == 12); wr_addr = 5'd7; wr_data = 16'h7777; wr_be = 2'b11;
      clear_req = (i == 5);
      step();
    end
    idle_in();
    total++;
    if (n != 16) begin
      $display("FAIL busy_len got %0d want 16", n);
    end else passed++;
    total++;
    if (va != 0 || vb != 0) begin
      $display("FAIL busy_read_valid a=%0d b=%0d want 0", va, vb);
    end else passed++;
    rd_en = 1; rd_addr = 5'd7;
    step();
    rd_en = 0;
    total++;
    if (rd_data_a !== 16'hA5A5 || rd_valid_a !== 1'b1) begin
      $display("FAIL busy_write_drop got %h/%b want a5a5/1",
               rd_data_a, rd_valid_a);
    end else passed++;
    step();
  endtask

  task automatic test_reset_mid_sweep();
    int na, nb;
    wr(5'd12, 16'hCCCC, 2'b11);
    rd_en = 1; rd_addr = 5'd12;
    step(); step();
    rd_en = 0;
    clear_req = 1;
    step();
    clear_req = 0;
    for (int i = 0; i < 9; i++) step();
    rst_n = 0;
    #1;
    total++;
    if (busy_a !== 1'b1 || rd_data_a !== 16'h0 || rd_valid_a !== 1'b0 ||
        rd_data_b !== 16'h0 || rd_valid_b !== 1'b0) begin
      $display("FAIL mid_reset busy=%b a=%h/%b b=%h/%b want 1 0/0 0/0",
               busy_a, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
    end else passed++;
    step(); step();
    rst_n = 1;
    na = 0; nb = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      step();
    end
    total++;
    if (na != 16 || nb != 16) begin
      $display("FAIL mid_restart_len a=%0d b=%0d want 16", na, nb);
    end else passed++;
    rd_en = 1; rd_addr = 5'd12;
    step();
    rd_addr = 5'd0;
    total++;
    if (rd_data_a !== 16'hA5A5) begin
      $display("FAIL mid_restart_a12 got %h want a5a5", rd_data_a);
    end else passed++;
    step();
    rd_en = 0;
    total++;
    if (rd_data_a !== 16'hA5A5) begin
      $display("FAIL mid_restart_a0 got %h want a5a5", rd_data_a);
    end else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_clear_contents();
    test_byte_enables();
    test_rdw();
    test_out_of_range();
    test_back_to_back();
    test_busy_gating();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
